// File: rtl/pulp_pwr_pkg.sv
// Shared types and elaboration helpers for the power-domain clamp sequencer.
package pulp_pwr_pkg;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    UP_SW     = 3'd1,
    UP_SETTLE = 3'd2,
    ON        = 3'd3,
    DN_CLAMP  = 3'd4,
    DN_SW     = 3'd5,
    FAULT     = 3'd6
  } state_e;

  function automatic bit params_ok(int unsigned setup, int unsigned settle,
                                   int unsigned timeout);
    return (setup >= 1) && (settle >= 1) && (timeout >= 2);
  endfunction

  function automatic int unsigned max3(int unsigned a, int unsigned b,
                                       int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pulp_pwr_timer.sv
// Saturating down-counter shared by all timed sequencer states.
module pulp_pwr_timer #(
  parameter int unsigned W = 9
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulp_pwr_clamp_seq.sv
// Power-domain sequencer: orders clamp and power-switch so the clamp is held
// whenever the domain is not confirmed on and settled.
//
// state     | meaning
// OFF       | switch open, clamp applied, idle
// UP_SW     | switch closing, waiting for ack (timeout)
// UP_SETTLE | ack seen, waiting for supply to settle
// ON        | domain powered, clamp released
// DN_CLAMP  | clamp applied, holding before opening switch
// DN_SW     | switch opening, waiting for ack to drop (timeout)
// FAULT     | ack lost unexpectedly, one cycle before OFF
module pulp_pwr_clamp_seq
  import pulp_pwr_pkg::*;
#(
  parameter int unsigned CLAMP_SETUP_CYCLES = 4,
  parameter int unsigned PWR_SETTLE_CYCLES  = 16,
  parameter int unsigned ACK_TIMEOUT        = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_valid_i,
  input  logic req_on_i,
  output logic req_ready_o,
  input  logic pwr_sw_ack_i,
  output logic pwr_sw_en_o,
  output logic clamp_o,
  output logic domain_on_o,
  output logic done_o,
  output logic err_o
);

  localparam int unsigned MAX_C = max3(CLAMP_SETUP_CYCLES, PWR_SETTLE_CYCLES, ACK_TIMEOUT);
  localparam int unsigned CNT_W = $clog2(MAX_C + 1);

  // Load N-1 so the FSM spends exactly N cycles in each timed state.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(CLAMP_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(PWR_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD     = CNT_W'(ACK_TIMEOUT - 1);

  if (!params_ok(CLAMP_SETUP_CYCLES, PWR_SETTLE_CYCLES, ACK_TIMEOUT)) begin : g_param_chk
    $error("pulp_pwr_clamp_seq: parameter below minimum");
  end

  state_e           state_q, state_d;
  logic             clamp_q, clamp_d;
  logic             en_q, en_d;
  logic             on_q, on_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             inflight_q, inflight_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;
  logic             accept;

  assign accept = req_valid_i & ready_q;

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    err_d      = err_q;
    inflight_d = inflight_q;
    tmr_load   = 1'b0;
    tmr_val    = TO_LD;
    unique case (state_q)
      OFF: begin
        if (accept) begin
          err_d = 1'b0;
          if (req_on_i) begin
            state_d  = UP_SW;
            tmr_load = 1'b1;
            tmr_val  = TO_LD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      UP_SW: begin
        if (pwr_sw_ack_i) begin
          state_d  = UP_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end else if (tmr_zero) begin
          state_d = OFF;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      UP_SETTLE: begin
        if (!pwr_sw_ack_i) begin
          state_d    = FAULT;
          err_d      = 1'b1;
          inflight_d = 1'b1;
        end else if (tmr_zero) begin
          state_d = ON;
          done_d  = 1'b1;
        end
      end
      ON: begin
        // Lost ack wins over a same-cycle request; that request ends errored.
        if (!pwr_sw_ack_i) begin
          state_d    = FAULT;
          err_d      = 1'b1;
          inflight_d = accept;
        end else if (accept) begin
          err_d = 1'b0;
          if (!req_on_i) begin
            state_d  = DN_CLAMP;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      DN_CLAMP: begin
        if (tmr_zero) begin
          state_d  = DN_SW;
          tmr_load = 1'b1;
          tmr_val  = TO_LD;
        end
      end
      DN_SW: begin
        if (!pwr_sw_ack_i) begin
          state_d = OFF;
          done_d  = 1'b1;
        end else if (tmr_zero) begin
          state_d = OFF;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      FAULT: begin
        state_d    = OFF;
        done_d     = inflight_q;
        inflight_d = 1'b0;
      end
      default: state_d = OFF;
    endcase
  end

  assign tmr_dec = (state_q == UP_SW) || (state_q == UP_SETTLE) ||
                   (state_q == DN_CLAMP) || (state_q == DN_SW);

  // Outputs are decoded from the next state and registered, so they switch
  // together with the state register.
  always_comb begin
    clamp_d = (state_d != ON);
    en_d    = (state_d == UP_SW) || (state_d == UP_SETTLE) ||
              (state_d == ON) || (state_d == DN_CLAMP);
    on_d    = (state_d == ON);
    ready_d = (state_d == OFF) || (state_d == ON);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= OFF;
      clamp_q    <= 1'b1;
      en_q       <= 1'b0;
      on_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clamp_q    <= clamp_d;
      en_q       <= en_d;
      on_q       <= on_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      inflight_q <= inflight_d;
    end
  end

  pulp_pwr_timer #(.W(CNT_W)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign clamp_o     = clamp_q;
  assign pwr_sw_en_o = en_q;
  assign domain_on_o = on_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign req_ready_o = ready_q;

endmodule

// File: tb/tb_pulp_pwr_clamp_seq.sv
// Scoreboard bench for pulp_pwr_clamp_seq with default parameters.
module tb_pulp_pwr_clamp_seq;
  import pulp_pwr_pkg::*;

  localparam int S_CLAMP = 0, S_EN = 1, S_ON = 2, S_DONE = 3, S_ERR = 4, S_RDY = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_valid = 1'b0;
  logic req_on = 1'b0;
  logic pwr_sw_ack = 1'b0;
  logic req_ready, pwr_sw_en, clamp, domain_on, done, err;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int    cyc;
    int    sig;
    logic  exp;
    string tag;
  } exp_t;
  exp_t sb_q[$];

  pulp_pwr_clamp_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_on_i     (req_on),
    .req_ready_o  (req_ready),
    .pwr_sw_ack_i (pwr_sw_ack),
    .pwr_sw_en_o  (pwr_sw_en),
    .clamp_o      (clamp),
    .domain_on_o  (domain_on),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic sig_val(int s);
    case (s)
      S_CLAMP: return clamp;
      S_EN:    return pwr_sw_en;
      S_ON:    return domain_on;
      S_DONE:  return done;
      S_ERR:   return err;
      default: return req_ready;
    endcase
  endfunction

  task automatic expect_at(int c, int sig, logic v, string tag);
    exp_t e;
    e.cyc = c; e.sig = sig; e.exp = v; e.tag = tag;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        check_eq(sb_q[i].tag, {31'd0, sig_val(sb_q[i].sig)}, {31'd0, sb_q[i].exp});
        sb_q.delete(i);
      end
    end
  end

  task automatic pulse_req(logic on_v);
    req_valid = 1'b1;
    req_on    = on_v;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  a_clamp_on: assert property (@(negedge clk) disable iff (!rst_n)
                               !clamp |-> (domain_on && pwr_sw_en));
  a_ready: assert property (@(negedge clk) disable iff (!rst_n)
                            !(dut.state_q inside {OFF, ON}) |-> !req_ready);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, x, drain;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_clamp", {31'd0, clamp}, 32'd1);
    check_eq("rst_en",    {31'd0, pwr_sw_en}, 32'd0);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_done",  {31'd0, done}, 32'd0);
    check_eq("rst_err",   {31'd0, err}, 32'd0);
    check_eq("rst_on",    {31'd0, domain_on}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: idle hold
    t = cyc;
    for (int k = 1; k <= 50; k++) begin
      expect_at(t + k, S_CLAMP, 1'b1, "idle_clamp");
      expect_at(t + k, S_EN,    1'b0, "idle_en");
      expect_at(t + k, S_RDY,   1'b1, "idle_ready");
    end
    wait_to(t + 51);

    // 2: power up, ack at t+5
    t = cyc;
    expect_at(t + 1,  S_EN,    1'b1, "up_en");
    expect_at(t + 1,  S_RDY,   1'b0, "up_busy");
    expect_at(t + 1,  S_CLAMP, 1'b1, "up_clamp_held");
    expect_at(t + 21, S_CLAMP, 1'b1, "up_clamp_pre");
    expect_at(t + 21, S_DONE,  1'b0, "up_done_pre");
    expect_at(t + 22, S_CLAMP, 1'b0, "up_clamp_rel");
    expect_at(t + 22, S_DONE,  1'b1, "up_done");
    expect_at(t + 22, S_ON,    1'b1, "up_on");
    expect_at(t + 22, S_RDY,   1'b1, "up_ready");
    expect_at(t + 23, S_DONE,  1'b0, "up_done_pulse");
    pulse_req(1'b1);
    wait_to(t + 5);
    pwr_sw_ack = 1'b1;
    wait_to(t + 25);

    // 3: power down, ack low at t+9
    t = cyc;
    expect_at(t + 1,  S_CLAMP, 1'b1, "dn_clamp");
    expect_at(t + 1,  S_EN,    1'b1, "dn_en_held");
    expect_at(t + 4,  S_EN,    1'b1, "dn_en_pre");
    expect_at(t + 5,  S_EN,    1'b0, "dn_en_off");
    expect_at(t + 9,  S_DONE,  1'b0, "dn_done_pre");
    expect_at(t + 10, S_DONE,  1'b1, "dn_done");
    expect_at(t + 10, S_RDY,   1'b1, "dn_ready");
    expect_at(t + 10, S_ON,    1'b0, "dn_on");
    expect_at(t + 10, S_ERR,   1'b0, "dn_err");
    expect_at(t + 11, S_DONE,  1'b0, "dn_done_pulse");
    pulse_req(1'b0);
    wait_to(t + 9);
    pwr_sw_ack = 1'b0;
    wait_to(t + 12);

    // 4: up with no ack -> timeout
    t = cyc;
    expect_at(t + 1,   S_EN,   1'b1, "to_en");
    expect_at(t + 256, S_EN,   1'b1, "to_en_pre");
    expect_at(t + 256, S_ERR,  1'b0, "to_err_pre");
    expect_at(t + 257, S_EN,   1'b0, "to_en_off");
    expect_at(t + 257, S_ERR,  1'b1, "to_err");
    expect_at(t + 257, S_DONE, 1'b1, "to_done");
    expect_at(t + 257, S_CLAMP,1'b1, "to_clamp");
    expect_at(t + 258, S_DONE, 1'b0, "to_done_pulse");
    expect_at(t + 259, S_ERR,  1'b1, "to_err_sticky");
    pulse_req(1'b1);
    wait_to(t + 260);
    t = cyc;
    expect_at(t + 1, S_ERR,  1'b0, "clr_err");
    expect_at(t + 1, S_DONE, 1'b1, "off_noop_done");
    pulse_req(1'b0);
    wait_to(t + 3);

    // 5: ack drops while ON
    t = cyc;
    pwr_sw_ack = 1'b1;
    expect_at(t + 18, S_ON, 1'b1, "f_on");
    pulse_req(1'b1);
    wait_to(t + 20);
    x = cyc;
    pwr_sw_ack = 1'b0;
    expect_at(x + 1, S_CLAMP, 1'b1, "f_clamp");
    expect_at(x + 1, S_EN,    1'b0, "f_en");
    expect_at(x + 1, S_ERR,   1'b1, "f_err");
    expect_at(x + 1, S_RDY,   1'b0, "f_busy");
    expect_at(x + 2, S_DONE,  1'b0, "f_no_done");
    expect_at(x + 2, S_RDY,   1'b1, "f_ready");
    expect_at(x + 2, S_ERR,   1'b1, "f_err_sticky");
    wait_to(x + 3);

    // fault coinciding with a down request
    t = cyc;
    pwr_sw_ack = 1'b1;
    expect_at(t + 1,  S_ERR, 1'b0, "fr_err_clr");
    expect_at(t + 18, S_ON,  1'b1, "fr_on");
    pulse_req(1'b1);
    wait_to(t + 20);
    x = cyc;
    pwr_sw_ack = 1'b0;
    expect_at(x + 1, S_ERR,   1'b1, "fr_err");
    expect_at(x + 1, S_CLAMP, 1'b1, "fr_clamp");
    expect_at(x + 2, S_DONE,  1'b1, "fr_done");
    expect_at(x + 2, S_ERR,   1'b1, "fr_err_hold");
    pulse_req(1'b0);
    wait_to(x + 4);

    // 6: async reset in UP_SETTLE
    t = cyc;
    pwr_sw_ack = 1'b1;
    expect_at(t + 4, S_EN, 1'b1, "rs_en_pre");
    pulse_req(1'b1);
    wait_to(t + 5);
    rst_n = 1'b0;
    #1;
    check_eq("rs_clamp", {31'd0, clamp}, 32'd1);
    check_eq("rs_en",    {31'd0, pwr_sw_en}, 32'd0);
    check_eq("rs_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rs_on",    {31'd0, domain_on}, 32'd0);
    check_eq("rs_err",   {31'd0, err}, 32'd0);
    check_eq("rs_done",  {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pwr_sw_ack = 1'b0;
    repeat (3) @(negedge clk);

    drain = 0;
    while (sb_q.size() != 0 && drain < 1000) begin
      @(negedge clk);
      drain++;
    end
    check_eq("sb_drain", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
